pe_mac_sequencer: RTL and testbench
===================================

Name: pe_mac_sequencer

Overview:
Sequences one processing element through a full dot-product job. It loads N kernel/neuron word pairs into the PE's two local stores over a valid/ready stream, then steps the read addresses across both stores. It also holds the partial-sum register that closes the PE's combinational multiply-add loop (adderOut -> register -> adderIn). It sits between the array-level scheduler and a single PE.

Parameters:
W, 16, datapath word width (kernel, neuron, partial sum)
A, 7, local store address width; max job length 2^A

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  reset, asynchronous, active-high
start  in  1  job request, sampled in IDLE only
len  in  A+1  job length N; legal range 1..2^A; sampled with start
in_valid  in  1  load stream valid
in_ready  out  1  load stream ready
kernel_in  in  W  kernel word of current pair
neuron_in  in  W  neuron word of current pair
kernel_write  out  1  PE kernel store write strobe
neuron_write  out  1  PE neuron store write strobe
kernel_data  out  W  data to PE kernel store
neuron_data  out  W  data to PE neuron store
store_address  out  A  shared write/read address to both stores
psum_in  in  W  PE adderOut
psum_out  out  W  partial-sum register, drives PE adderIn
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse, result valid on psum_out
result  out  W  final sum, held until the next job completes

Behaviour:
- Reset (async, RST=1): state=IDLE. All outputs 0: in_ready, write strobes, store_address, psum_out, busy, done, result.
- IDLE: if start=1 and len!=0, latch N=len, clear the counter and psum_out, go to LOAD. start with len=0 is ignored and stays in IDLE. start while busy is ignored.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: kernel_write=neuron_write=1, kernel_data/neuron_data are the inputs combinationally, store_address=count, count++.
  - When the last pair (count==N-1) is accepted, go to COMPUTE with count=0.
  - With no handshake, strobes are 0 and the address holds.
- COMPUTE:
  - in_ready=0. store_address=count, one address per cycle.
  - The stores read synchronously, so data for address a appears at the multiplier in the cycle after a is presented.
  - A one-cycle delayed valid bit acc_v gates accumulation: when acc_v=1, psum_out <= psum_in.
  - After address N-1 is issued, go to DRAIN.
- DRAIN: one cycle. The final accumulate occurs (acc_v=1). Then go to DONE.
- DONE: done=1 for exactly one cycle, result <= psum_out (post-final-accumulate value), busy=1. Next state is IDLE.
- Latency: start accepted -> first in_ready is 1 cycle. Last load handshake -> done is N+2 cycles.
- Arithmetic: W-bit wrap-around, with no saturation and no overflow flag. psum_out is cleared only on job start.
- Boundaries:
  - N=1: LOAD takes one handshake; COMPUTE lasts one cycle.
  - N=2^A: count wraps address 2^A-1 -> terminal. len is A+1 bits so it can encode 2^A.
  - Values of len above 2^A are illegal. In that case N is clamped to 2^A.
  - RST mid-job returns to IDLE immediately, and the store contents are unspecified.

Decomposition:
- A shared package holds the state encoding (IDLE, LOAD, COMPUTE, DRAIN, DONE) and W/A defaults, for reuse by the array scheduler.
- One natural sub-module: pe_addr_counter. It is an A-bit up-counter with clear, enable and a terminal-count compare against N-1, used in both LOAD and COMPUTE.
- The FSM, acc_v pipeline bit and psum/result registers stay in the top.

Test Plan:
- Reset: assert RST mid-COMPUTE -> all outputs 0 asynchronously; after release, start with len=2 behaves normally.
- Basic job: len=3, pairs (1,2),(3,4),(5,6) with in_valid held high -> addresses 0,1,2 written, then read 0,1,2. done arrives 5 cycles after the last handshake with result=44, driving a behavioural PE model.
- Backpressure: len=4 with in_valid toggled 1,0,0,1,1,0,1 -> writes only on handshakes, addresses 0..3 contiguous, result correct.
- Edge lengths: len=1 with pair (7,9) -> result=63, done 3 cycles after the handshake. len=128 with all pairs (1,1) -> result=128 and the address wraps cleanly.
- Overflow and ignored requests: len=2 with pairs (0x8000,2),(1,1) -> result=0x0001 (wrap). start pulsed while busy and start with len=0 -> no effect, busy is unchanged.

Source files
------------

// File: rtl/pe_mac_sequencer_pkg.sv
// pe_mac_sequencer_pkg: shared job-sequencer state encoding and default widths
package pe_mac_sequencer_pkg;
  localparam int W_DEF = 16;
  localparam int A_DEF = 7;
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} state_t;
endpackage

// File: rtl/pe_mac_sequencer_addr_counter.sv
// pe_addr_counter: store address counter that wraps to zero on reaching its terminal value
module pe_addr_counter #(
  parameter int A = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [A-1:0] last,
  output logic [A-1:0] count,
  output logic         term
);
  assign term = count == last;
  // wrapping at the terminal value leaves the counter at 0 for the next phase
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else count <= clr ? '0 : en ? (term ? '0 : count + A'(1)) : count;
endmodule

// File: rtl/pe_mac_sequencer.sv
// pe_mac_sequencer: loads a PE's kernel/neuron stores, then steps reads and accumulates the dot product
module pe_mac_sequencer
  import pe_mac_sequencer_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int A = A_DEF
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [A:0]   len,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] kernel_in,
  input  logic [W-1:0] neuron_in,
  output logic         kernel_write,
  output logic         neuron_write,
  output logic [W-1:0] kernel_data,
  output logic [W-1:0] neuron_data,
  output logic [A-1:0] store_address,
  input  logic [W-1:0] psum_in,
  output logic [W-1:0] psum_out,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);
  state_t state;
  logic [A-1:0] last;
  logic term, hs, go, acc_v;
  assign go = state == IDLE && start && len != '0;
  assign hs = state == LOAD && in_valid;
  assign in_ready = state == LOAD;
  assign kernel_write = hs;
  assign neuron_write = hs;
  assign kernel_data = hs ? kernel_in : '0;
  assign neuron_data = hs ? neuron_in : '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  pe_addr_counter #(.A(A)) u_cnt (
    .clk(CLK),
    .rst(RST),
    .clr(go),
    .en(hs || state == COMPUTE),
    .last(last),
    .count(store_address),
    .term(term)
  );
  // job FSM; last holds N-1, with lengths of 2^A or more clamped to 2^A
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      last <= '0;
    end else
      case (state)
        IDLE: if (go) begin
          state <= LOAD;
          last <= len[A] ? '1 : len[A-1:0] - A'(1);
        end
        LOAD: if (hs && term) state <= COMPUTE;
        COMPUTE: if (term) state <= DRAIN;
        DRAIN: state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
  // acc_v trails each issued read address by one cycle to match the synchronous store read
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      acc_v <= 1'b0;
      psum_out <= '0;
      result <= '0;
    end else begin
      acc_v <= state == COMPUTE;
      psum_out <= go ? '0 : acc_v ? psum_in : psum_out;
      result <= done ? psum_out : result;
    end
endmodule

// File: tb/tb_pe_mac_sequencer.sv
// tb_pe_mac_sequencer: directed jobs against a behavioural PE with hand-computed dot products
module tb_pe_mac_sequencer;
  localparam int W = 16;
  localparam int A = 7;
  logic CLK = 0, RST = 1, start = 0, in_valid = 0;
  logic [A:0] len = '0;
  logic [W-1:0] kernel_in = '0, neuron_in = '0;
  logic in_ready, kernel_write, neuron_write, busy, done;
  logic [W-1:0] kernel_data, neuron_data, psum_in, psum_out, result;
  logic [A-1:0] store_address;
  int checks = 0, fails = 0;
  logic [W-1:0] kq [0:255];
  logic [W-1:0] nq [0:255];
  bit vp [0:15];
  int vp_len = 0;

  pe_mac_sequencer dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready),
    .kernel_in(kernel_in), .neuron_in(neuron_in),
    .kernel_write(kernel_write), .neuron_write(neuron_write),
    .kernel_data(kernel_data), .neuron_data(neuron_data),
    .store_address(store_address), .psum_in(psum_in), .psum_out(psum_out),
    .busy(busy), .done(done), .result(result)
  );

  always #5 CLK = ~CLK;

  // behavioural PE: two synchronous-read stores feeding a multiply-add
  logic [W-1:0] kmem [0:127];
  logic [W-1:0] nmem [0:127];
  logic [W-1:0] rk = '0, rn = '0;
  always @(posedge CLK) begin
    if (kernel_write) kmem[store_address] <= kernel_data;
    if (neuron_write) nmem[store_address] <= neuron_data;
    rk <= kmem[store_address];
    rn <= nmem[store_address];
  end
  assign psum_in = psum_out + rk * rn;

  task automatic run_job(input int n, input int n_eff, input bit poke,
                         output int lat, output logic [W-1:0] fin,
                         output logic [W-1:0] res, output int errs);
    int idx, pi;
    bit hs;
    errs = 0; fin = '0; res = '0; lat = -1;
    @(posedge CLK); #1 start = 1; len = n[A:0];
    @(posedge CLK); #1 start = 0; len = '0;
    idx = 0; pi = 0;
    while (idx < n_eff && pi < 1000) begin
      in_valid = (vp_len == 0) ? 1'b1 : vp[pi % vp_len];
      kernel_in = kq[idx]; neuron_in = nq[idx];
      if (poke && pi == 0) begin start = 1; len = 5; end
      @(negedge CLK);
      hs = in_valid && in_ready;
      if (!in_ready || !busy || store_address != idx[A-1:0] || kernel_write !== in_valid ||
          neuron_write !== in_valid ||
          (in_valid && (kernel_data !== kernel_in || neuron_data !== neuron_in))) errs++;
      @(posedge CLK); #1 start = 0; len = '0;
      if (hs) idx++;
      pi++;
    end
    in_valid = 0;
    if (idx < n_eff) begin errs++; return; end
    lat = 0;
    do begin
      lat++;
      @(negedge CLK);
      if (lat <= n_eff && (store_address != 7'(lat - 1) || in_ready !== 1'b0 || kernel_write !== 1'b0)) errs++;
    end while (!done && lat < n_eff + 20);
    fin = psum_out;
    if (!done) lat = -1;
    @(posedge CLK); #1 res = result;
    @(negedge CLK);
    if (busy !== 1'b0 || done !== 1'b0) errs++;
  endtask

  task automatic test_reset();
    int lat, errs;
    logic [W-1:0] fin, res;
    #2;
    checks++;
    if ({in_ready, kernel_write, neuron_write, store_address, psum_out, busy, done, result} !== '0) begin
      fails++; $display("FAIL reset_init: outputs=%h required 0",
        {in_ready, kernel_write, neuron_write, store_address, psum_out, busy, done, result});
    end
    @(negedge CLK); RST = 0;
    kq[0] = 1; nq[0] = 2; kq[1] = 3; nq[1] = 4; kq[2] = 5; nq[2] = 6;
    @(posedge CLK); #1 start = 1; len = 3;
    @(posedge CLK); #1 start = 0; len = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      kernel_in = kq[i]; neuron_in = nq[i];
      @(posedge CLK); #1;
    end
    in_valid = 0;
    @(posedge CLK); @(posedge CLK); #3;
    checks++;
    if (busy !== 1'b1 || store_address !== 7'd2 || psum_out !== 16'd2) begin
      fails++; $display("FAIL reset_precond: busy=%b addr=%0d psum=%0d required 1/2/2", busy, store_address, psum_out);
    end
    RST = 1; #1;
    checks++;
    if ({in_ready, kernel_write, neuron_write, store_address, psum_out, busy, done, result} !== '0) begin
      fails++; $display("FAIL reset_async: outputs=%h required 0",
        {in_ready, kernel_write, neuron_write, store_address, psum_out, busy, done, result});
    end
    @(negedge CLK); RST = 0;
    kq[0] = 3; nq[0] = 5; kq[1] = 2; nq[1] = 2; vp_len = 0;
    run_job(2, 2, 0, lat, fin, res, errs);
    checks++;
    if (lat !== 4 || res !== 16'd19 || errs !== 0) begin
      fails++; $display("FAIL reset_recover: lat=%0d res=%0d errs=%0d required 4/19/0", lat, res, errs);
    end
  endtask

  task automatic test_basic();
    int lat, errs;
    logic [W-1:0] fin, res;
    for (int i = 0; i < 3; i++) begin kq[i] = 16'(2 * i + 1); nq[i] = 16'(2 * i + 2); end
    vp_len = 0;
    run_job(3, 3, 0, lat, fin, res, errs);
    checks++;
    if (lat !== 5) begin fails++; $display("FAIL basic_latency: got %0d required 5", lat); end
    checks++;
    if (fin !== 16'd44) begin fails++; $display("FAIL basic_psum_at_done: got %0d required 44", fin); end
    checks++;
    if (res !== 16'd44) begin fails++; $display("FAIL basic_result: got %0d required 44", res); end
    checks++;
    if (errs !== 0) begin fails++; $display("FAIL basic_sequence: %0d bad cycles required 0", errs); end
  endtask

  task automatic test_backpressure();
    int lat, errs;
    logic [W-1:0] fin, res;
    for (int i = 0; i < 4; i++) begin kq[i] = 16'(2 * i + 2); nq[i] = 16'(2 * i + 3); end
    {vp[0], vp[1], vp[2], vp[3], vp[4], vp[5], vp[6]} = 7'b1001101;
    vp_len = 7;
    run_job(4, 4, 0, lat, fin, res, errs);
    vp_len = 0;
    checks++;
    if (lat !== 6 || res !== 16'd140) begin
      fails++; $display("FAIL backpressure_result: lat=%0d res=%0d required 6/140", lat, res);
    end
    checks++;
    if (errs !== 0) begin fails++; $display("FAIL backpressure_sequence: %0d bad cycles required 0", errs); end
  endtask

  task automatic test_edge_lengths();
    int lat, errs;
    logic [W-1:0] fin, res;
    kq[0] = 7; nq[0] = 9;
    run_job(1, 1, 0, lat, fin, res, errs);
    checks++;
    if (lat !== 3 || res !== 16'd63 || errs !== 0) begin
      fails++; $display("FAIL len1: lat=%0d res=%0d errs=%0d required 3/63/0", lat, res, errs);
    end
    for (int i = 0; i < 128; i++) begin kq[i] = 1; nq[i] = 1; end
    run_job(128, 128, 0, lat, fin, res, errs);
    checks++;
    if (lat !== 130 || res !== 16'd128 || errs !== 0) begin
      fails++; $display("FAIL len128: lat=%0d res=%0d errs=%0d required 130/128/0", lat, res, errs);
    end
    checks++;
    if (store_address !== 7'd0) begin fails++; $display("FAIL len128_wrap: addr=%0d required 0", store_address); end
    for (int i = 0; i < 128; i++) begin kq[i] = 16'(i); nq[i] = 1; end
    run_job(200, 128, 0, lat, fin, res, errs);
    checks++;
    if (lat !== 130 || res !== 16'd8128 || errs !== 0) begin
      fails++; $display("FAIL len_clamp: lat=%0d res=%0d errs=%0d required 130/8128/0", lat, res, errs);
    end
  endtask

  task automatic test_overflow_ignored();
    int lat, errs;
    logic [W-1:0] fin, res;
    kq[0] = 16'h8000; nq[0] = 2; kq[1] = 1; nq[1] = 1;
    run_job(2, 2, 1, lat, fin, res, errs);
    checks++;
    if (lat !== 4 || res !== 16'h0001 || errs !== 0) begin
      fails++; $display("FAIL overflow_busy_start: lat=%0d res=%h errs=%0d required 4/0001/0", lat, res, errs);
    end
    @(posedge CLK); #1 start = 1; len = 0;
    @(posedge CLK); #1 start = 0;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      fails++; $display("FAIL len0_ignored: busy=%b in_ready=%b required 0/0", busy, in_ready);
    end
    checks++;
    if (result !== 16'h0001) begin fails++; $display("FAIL result_held: got %h required 0001", result); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_edge_lengths();
    test_overflow_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
